// File: rtl/game_ctrl.sv
// Canoe-crossing timing game controller: button conditioning, blink divider,
// level-scaled step timer and game FSM. Optional win counter under `GAME_SCORE_EN.
module game_ctrl #(
  parameter int BLINK_DIV = 24_691_358,
  parameter int BASE_STEP = 50_000_000,
  parameter int WIN_POS   = 13
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sw6,
  input  logic       sw5,
  input  logic       btn_go,
  input  logic       btn_lvl,
  output logic       count_2_025Hz,
  output logic [1:0] gameState,
  output logic [3:0] cnt_canoe,
  output logic [1:0] level,
  output logic [3:0] score
);

  typedef enum logic [1:0] {
    S_LOSE  = 2'd0,
    S_WIN   = 2'd1,
    S_PLAY  = 2'd2,
    S_READY = 2'd3
  } state_t;

  localparam int BLINK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam int STEP_W  = (BASE_STEP > 1) ? $clog2(BASE_STEP) : 1;
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
  localparam logic [3:0]         WIN_CNT    = 4'(WIN_POS);

  state_t             state, state_nxt;
  logic [3:0]         cnt_nxt;
  logic [1:0]         level_nxt;
  logic               step_clr;
  logic [1:0]         go_sync, lvl_sync;
  logic               go_prev, lvl_prev;
  logic               go_pulse, lvl_pulse;
  logic [BLINK_W-1:0] blink_cnt;
  logic [STEP_W-1:0]  step_cnt, step_last;
  logic               run, tick;

  // Two-flop synchronisers for the raw buttons, plus a prev flop for rise detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      go_sync  <= '0;
      lvl_sync <= '0;
      go_prev  <= 1'b0;
      lvl_prev <= 1'b0;
    end else begin
      go_sync  <= {go_sync[0], btn_go};
      lvl_sync <= {lvl_sync[0], btn_lvl};
      go_prev  <= go_sync[1];
      lvl_prev <= lvl_sync[1];
    end
  end

  assign go_pulse  = go_sync[1] & ~go_prev;
  assign lvl_pulse = lvl_sync[1] & ~lvl_prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blink_cnt     <= '0;
      count_2_025Hz <= 1'b0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt     <= '0;
      count_2_025Hz <= ~count_2_025Hz;
    end else begin
      blink_cnt <= blink_cnt + BLINK_W'(1);
    end
  end

  // Each level halves the step period.
  assign step_last = STEP_W'((BASE_STEP >> level) - 1);
  assign run       = (state == S_PLAY) && sw6 && !sw5;
  assign tick      = run && (step_cnt == step_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_cnt <= '0;
    end else if (step_clr) begin
      step_cnt <= '0;
    end else if (run) begin
      step_cnt <= tick ? '0 : step_cnt + STEP_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_READY;
      cnt_canoe <= '0;
      level     <= '0;
    end else begin
      state     <= state_nxt;
      cnt_canoe <= cnt_nxt;
      level     <= level_nxt;
    end
  end

  // NOTE: every variable gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt_canoe;
    level_nxt = level;
    step_clr  = 1'b0;
    if (!sw6) begin
      state_nxt = S_READY;
      cnt_nxt   = '0;
    end else begin
      unique case (state)
        S_READY: begin
          if (sw5) begin
            if (lvl_pulse) begin
              level_nxt = level + 2'd1;
              step_clr  = 1'b1;
            end
          end else if (go_pulse) begin
            state_nxt = S_PLAY;
            cnt_nxt   = '0;
            step_clr  = 1'b1;
          end
        end
        S_PLAY: begin
          // A press takes priority over a coincident tick and is judged on the current position.
          if (!sw5) begin
            if (go_pulse) begin
              state_nxt = (cnt_canoe >= WIN_CNT) ? S_WIN : S_LOSE;
            end else if (tick) begin
              if (cnt_canoe == 4'd15) state_nxt = S_LOSE;
              else                    cnt_nxt   = cnt_canoe + 4'd1;
            end
          end
        end
        default: begin
          if (go_pulse && !sw5) begin
            state_nxt = S_READY;
            cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

  always_comb begin
    gameState = state;
  end

`ifdef GAME_SCORE_EN
  logic win_evt;
  assign win_evt = (state == S_PLAY) && (state_nxt == S_WIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score <= '0;
    end else if (win_evt && (score != 4'd15)) begin
      score <= score + 4'd1;
    end
  end
`else
  assign score = 4'd0;
`endif

endmodule
